// File: rtl/apb_pkg.sv
// Shared APB definitions: arbiter FSM encoding, also used by the APB slave mux.
package apb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_arb_state_t;

endpackage

// File: rtl/apb_if.sv
// APB bus bundle; pstrb is the per-transfer select, psel carries byte lanes.
interface apb_if #(
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int SW = DW / 8
);
  logic          penable;
  logic          pwrite;
  logic          pstrb;
  logic [AW-1:0] paddr;
  logic [SW-1:0] psel;
  logic [DW-1:0] pwdata;
  logic [DW-1:0] prdata;
  logic          pready;
  logic          pslverr;

  modport master (
    output penable, pwrite, pstrb, paddr, psel, pwdata,
    input  prdata, pready, pslverr
  );

  modport slave (
    input  penable, pwrite, pstrb, paddr, psel, pwdata,
    output prdata, pready, pslverr
  );
endinterface

// File: rtl/apb_rr_arbiter.sv
// Combinational round-robin pick: first set request after 'last', wrapping modulo N.
module apb_rr_arbiter #(
  parameter int N  = 4,
  parameter int LW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [LW-1:0] last,
  output logic [LW-1:0] gnt_idx,
  output logic          gnt_vld
);

  logic [LW-1:0] idx;

  // Walk from the farthest candidate to the nearest so the nearest hit wins.
  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = '0;
    idx     = '0;
    for (int k = N; k >= 1; k--) begin
      idx = LW'((int'(last) + k) % N);
      if (req[idx]) begin
        gnt_vld = 1'b1;
        gnt_idx = idx;
      end
    end
  end

endmodule

// File: rtl/apb_arbiter.sv
// N-way round-robin requester front end driving a single APB master port.
module apb_arbiter
  import apb_pkg::*;
#(
  parameter int N  = 4,
  parameter int AW = 32,
  parameter int DW = 32,
  parameter int SW = DW / 8,
  parameter int TO = 256
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    req_vld,
  input  logic [N-1:0]    req_wen,
  input  logic [N*AW-1:0] req_adr,
  input  logic [N*SW-1:0] req_sel,
  input  logic [N*DW-1:0] req_wdt,
  output logic [N-1:0]    req_ack,
  output logic [DW-1:0]   rsp_rdt,
  output logic            rsp_err,
  apb_if.master           apb
);

  localparam int LW = $clog2(N);
  localparam int CW = (TO > 0) ? $clog2(TO + 1) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'((TO > 0) ? TO - 1 : 0);

  apb_arb_state_t state_q, state_d;
  logic [LW-1:0]  gnt_q, gnt_d;
  logic [LW-1:0]  last_q, last_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [N-1:0]   ack_q, ack_d;
  logic [DW-1:0]  rdt_q, rdt_d;
  logic           err_q, err_d;
  logic           penable_q, penable_d;
  logic           pwrite_q, pwrite_d;
  logic           pstrb_q, pstrb_d;
  logic [AW-1:0]  paddr_q, paddr_d;
  logic [SW-1:0]  psel_q, psel_d;
  logic [DW-1:0]  pwdata_q, pwdata_d;

  logic [N-1:0]   pending;
  logic [LW-1:0]  arb_idx;
  logic           arb_vld;
  logic           done;

  // The requester being acked still shows req_vld this cycle; keep it out.
  assign pending = req_vld & ~ack_q;

  apb_rr_arbiter #(.N(N), .LW(LW)) u_rr (
    .req     (pending),
    .last    (last_q),
    .gnt_idx (arb_idx),
    .gnt_vld (arb_vld)
  );

  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    last_d    = last_q;
    cnt_d     = cnt_q;
    ack_d     = '0;
    rdt_d     = rdt_q;
    err_d     = err_q;
    penable_d = penable_q;
    pwrite_d  = pwrite_q;
    pstrb_d   = pstrb_q;
    paddr_d   = paddr_q;
    psel_d    = psel_q;
    pwdata_d  = pwdata_q;
    done      = 1'b0;

    case (state_q)
      IDLE: begin
        if (arb_vld) begin
          gnt_d    = arb_idx;
          pwrite_d = req_wen[arb_idx];
          paddr_d  = req_adr[int'(arb_idx)*AW +: AW];
          psel_d   = req_sel[int'(arb_idx)*SW +: SW];
          pwdata_d = req_wdt[int'(arb_idx)*DW +: DW];
          pstrb_d  = 1'b1;
          state_d  = SETUP;
        end
      end
      SETUP: begin
        penable_d = 1'b1;
        cnt_d     = '0;
        state_d   = ACCESS;
      end
      ACCESS: begin
        // A slave answering on the final timeout cycle still gets its response through.
        if (apb.pready) begin
          rdt_d = apb.prdata;
          err_d = apb.pslverr;
          done  = 1'b1;
        end else if (TO != 0 && cnt_q == TO_LAST) begin
          rdt_d = '0;
          err_d = 1'b1;
          done  = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    if (done) begin
      pstrb_d      = 1'b0;
      penable_d    = 1'b0;
      ack_d[gnt_q] = 1'b1;
      last_d       = gnt_q;
      state_d      = IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      last_q    <= LW'(N - 1);
      cnt_q     <= '0;
      ack_q     <= '0;
      rdt_q     <= '0;
      err_q     <= 1'b0;
      penable_q <= 1'b0;
      pwrite_q  <= 1'b0;
      pstrb_q   <= 1'b0;
      paddr_q   <= '0;
      psel_q    <= '0;
      pwdata_q  <= '0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      last_q    <= last_d;
      cnt_q     <= cnt_d;
      ack_q     <= ack_d;
      rdt_q     <= rdt_d;
      err_q     <= err_d;
      penable_q <= penable_d;
      pwrite_q  <= pwrite_d;
      pstrb_q   <= pstrb_d;
      paddr_q   <= paddr_d;
      psel_q    <= psel_d;
      pwdata_q  <= pwdata_d;
    end
  end

  assign req_ack     = ack_q;
  assign rsp_rdt     = rdt_q;
  assign rsp_err     = err_q;
  assign apb.penable = penable_q;
  assign apb.pwrite  = pwrite_q;
  assign apb.pstrb   = pstrb_q;
  assign apb.paddr   = paddr_q;
  assign apb.psel    = psel_q;
  assign apb.pwdata  = pwdata_q;

endmodule

// File: tb/tb_apb_arbiter.sv
// Directed bench for apb_arbiter: expectations queued at issue, checked by a monitor.
module tb_apb_arbiter;
  localparam int N = 4, AW = 32, DW = 32, SW = 4, TO = 8, LIMIT = 100;

  typedef struct {logic wen; logic [31:0] adr; logic [3:0] sel; logic [31:0] wdt;} bus_t;
  typedef struct {logic [3:0] ack; logic [31:0] rdt; logic err;} rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [N-1:0]    req_vld = '0, req_wen = '0;
  logic [N*AW-1:0] req_adr = '0;
  logic [N*SW-1:0] req_sel = '0;
  logic [N*DW-1:0] req_wdt = '0;
  logic [N-1:0]    req_ack;
  logic [DW-1:0]   rsp_rdt;
  logic            rsp_err;

  int tests = 0, fails = 0;
  int slv_wait = 0;
  logic [31:0] slv_rdata = '0;
  logic slv_err = 1'b0;
  bus_t bus_q[$];
  rsp_t rsp_q[$];

  apb_if #(.AW(AW), .DW(DW), .SW(SW)) bus ();

  apb_arbiter #(.N(N), .AW(AW), .DW(DW), .SW(SW), .TO(TO)) dut (
    .clk(clk), .rst(rst), .req_vld(req_vld), .req_wen(req_wen), .req_adr(req_adr),
    .req_sel(req_sel), .req_wdt(req_wdt), .req_ack(req_ack), .rsp_rdt(rsp_rdt),
    .rsp_err(rsp_err), .apb(bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Slave: answers after slv_wait ACCESS cycles; prdata always driven.
  initial begin
    int acc;
    acc = 0;
    bus.pready = 1'b0; bus.prdata = '0; bus.pslverr = 1'b0;
    forever begin
      @(negedge clk);
      bus.prdata = slv_rdata;
      if (bus.pstrb && bus.penable) begin
        bus.pready  = (acc == slv_wait);
        bus.pslverr = (acc == slv_wait) ? slv_err : 1'b0;
        acc++;
      end else begin
        bus.pready = 1'b0; bus.pslverr = 1'b0; acc = 0;
      end
    end
  end

  // Monitor: SETUP-phase bus contents and ack responses against the queues.
  initial forever begin
    @(negedge clk);
    if (bus.pstrb && !bus.penable) begin
      if (bus_q.size() == 0) chk("setup_unexpected", bus_q.size(), 1);
      else begin
        bus_t b;
        b = bus_q.pop_front();
        chk("setup_pwrite", bus.pwrite, b.wen);
        chk("setup_paddr",  bus.paddr,  b.adr);
        chk("setup_psel",   bus.psel,   b.sel);
        chk("setup_pwdata", bus.pwdata, b.wdt);
      end
    end
    if (req_ack != '0) begin
      if (rsp_q.size() == 0) chk("ack_unexpected", req_ack, 0);
      else begin
        rsp_t r;
        r = rsp_q.pop_front();
        chk("rsp_ack", req_ack, r.ack);
        chk("rsp_rdt", rsp_rdt, r.rdt);
        chk("rsp_err", rsp_err, r.err);
      end
    end
  end

  task automatic set_req(input int i, input logic wen, input logic [31:0] adr,
                         input logic [3:0] sel, input logic [31:0] wdt);
    req_wen[i] = wen;
    req_adr[i*AW +: AW] = adr;
    req_sel[i*SW +: SW] = sel;
    req_wdt[i*DW +: DW] = wdt;
  endtask

  task automatic expect_xfer(input int i, input logic wen, input logic [31:0] adr,
                             input logic [3:0] sel, input logic [31:0] wdt,
                             input logic [31:0] rdt, input logic err);
    bus_t b;
    rsp_t r;
    logic [3:0] oh;
    oh = '0; oh[i] = 1'b1;
    b.wen = wen; b.adr = adr; b.sel = sel; b.wdt = wdt;
    r.ack = oh; r.rdt = rdt; r.err = err;
    bus_q.push_back(b);
    rsp_q.push_back(r);
  endtask

  task automatic wait_ack(output int cyc, output int pst, output int pen);
    cyc = LIMIT; pst = 0; pen = 0;
    for (int k = 1; k <= LIMIT; k++) begin
      @(negedge clk);
      pst += int'(bus.pstrb);
      pen += int'(bus.penable);
      if (req_ack != '0) begin
        cyc = k;
        break;
      end
    end
  endtask

  task automatic xfer(input int i, input logic wen, input logic [31:0] adr,
                      input logic [3:0] sel, input logic [31:0] wdt,
                      input logic [31:0] rdt, input logic err,
                      output int cyc, output int pst, output int pen);
    set_req(i, wen, adr, sel, wdt);
    expect_xfer(i, wen, adr, sel, wdt, rdt, err);
    req_vld[i] = 1'b1;
    wait_ack(cyc, pst, pen);
    req_vld[i] = 1'b0;
  endtask

  initial begin
    int c, p, e, acks;
    repeat (2) @(negedge clk);
    chk("rst_ack", req_ack, 0);
    chk("rst_rdt", rsp_rdt, 0);
    chk("rst_err", rsp_err, 0);
    chk("rst_pstrb", bus.pstrb, 0);
    chk("rst_penable", bus.penable, 0);
    chk("rst_pwrite", bus.pwrite, 0);
    chk("rst_paddr", bus.paddr, 0);
    chk("rst_psel", bus.psel, 0);
    chk("rst_pwdata", bus.pwdata, 0);
    rst = 1'b0;
    @(negedge clk);

    // Single write, zero wait states.
    slv_wait = 0; slv_rdata = 32'h0; slv_err = 1'b0;
    xfer(0, 1'b1, 32'h10, 4'hF, 32'hA5A5A5A5, 32'h0, 1'b0, c, p, e);
    chk("t1_cycles", c, 3); chk("t1_pstrb", p, 2); chk("t1_penable", e, 1);
    @(negedge clk);

    // Read with three wait states.
    slv_wait = 3; slv_rdata = 32'hDEADBEEF;
    xfer(2, 1'b0, 32'h40, 4'hF, 32'h0, 32'hDEADBEEF, 1'b0, c, p, e);
    chk("t2_cycles", c, 6); chk("t2_pstrb", p, 5); chk("t2_penable", e, 4);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Round robin with all four requesting after reset.
    slv_wait = 0; slv_rdata = 32'h0BADF00D;
    for (int i = 0; i < N; i++)
      set_req(i, logic'(i % 2), 32'h100 + 32'(i * 4), 4'(i + 1), 32'hC0DE0000 + 32'(i));
    for (int k = 0; k < 5; k++) begin
      int i;
      i = k % N;
      expect_xfer(i, logic'(i % 2), 32'h100 + 32'(i * 4), 4'(i + 1), 32'hC0DE0000 + 32'(i),
                  32'h0BADF00D, 1'b0);
    end
    req_vld = 4'hF;
    acks = 0; c = LIMIT;
    for (int k = 1; k <= LIMIT; k++) begin
      @(negedge clk);
      if (req_ack != '0) acks++;
      if (acks == 5) begin
        c = k;
        break;
      end
    end
    req_vld = '0;
    chk("t3_acks", acks, 5); chk("t3_cycles", c, 15);
    @(negedge clk);

    // Slave error, then an immediate re-request from the same source.
    slv_err = 1'b1; slv_rdata = 32'h1;
    xfer(1, 1'b1, 32'h200, 4'h3, 32'h12345678, 32'h1, 1'b1, c, p, e);
    chk("t4a_cycles", c, 3);
    slv_err = 1'b0; slv_rdata = 32'h55AA55AA;
    xfer(1, 1'b0, 32'h204, 4'hC, 32'h0, 32'h55AA55AA, 1'b0, c, p, e);
    chk("t4b_cycles", c, 4);
    @(negedge clk);

    // Timeout, then pready landing exactly on the last timeout cycle.
    slv_wait = 100; slv_rdata = 32'hFFFFFFFF;
    xfer(3, 1'b0, 32'h300, 4'hF, 32'h0, 32'h0, 1'b1, c, p, e);
    chk("t5_cycles", c, 10); chk("t5_penable", e, 8);
    @(negedge clk);
    slv_wait = 7; slv_rdata = 32'h600DD00D;
    xfer(0, 1'b0, 32'h304, 4'h1, 32'h0, 32'h600DD00D, 1'b0, c, p, e);
    chk("t5b_cycles", c, 10); chk("t5b_penable", e, 8);
    @(negedge clk);

    // Reset in ACCESS: no ack, outputs cleared, requester 0 first afterwards.
    slv_wait = 100;
    set_req(0, 1'b1, 32'h400, 4'hF, 32'hAAAA0000);
    set_req(1, 1'b1, 32'h404, 4'h7, 32'hBBBB0000);
    begin
      bus_t b;
      b.wen = 1'b1; b.adr = 32'h404; b.sel = 4'h7; b.wdt = 32'hBBBB0000;
      bus_q.push_back(b);
    end
    req_vld = 4'b0011;
    repeat (2) @(negedge clk);
    chk("t6_in_access", bus.penable, 1);
    rst = 1'b1;
    @(negedge clk);
    chk("t6_ack", req_ack, 0); chk("t6_pstrb", bus.pstrb, 0);
    chk("t6_penable", bus.penable, 0); chk("t6_paddr", bus.paddr, 0);
    chk("t6_pwdata", bus.pwdata, 0); chk("t6_pwrite", bus.pwrite, 0);
    rst = 1'b0; slv_wait = 0; slv_rdata = 32'h77;
    expect_xfer(0, 1'b1, 32'h400, 4'hF, 32'hAAAA0000, 32'h77, 1'b0);
    expect_xfer(1, 1'b1, 32'h404, 4'h7, 32'hBBBB0000, 32'h77, 1'b0);
    wait_ack(c, p, e);
    chk("t6_first", req_ack, 4'b0001); chk("t6_first_cycles", c, 3);
    req_vld[0] = 1'b0;
    wait_ack(c, p, e);
    chk("t6_second", req_ack, 4'b0010);
    req_vld = '0;
    repeat (3) @(negedge clk);

    chk("end_bus_q", bus_q.size(), 0);
    chk("end_rsp_q", rsp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
